seg7_scan_driver: RTL

- Time-multiplexed driver for an N-digit common-anode 7-segment display; successor to the single-digit hex-to-segment decoder.
- Each digit is a 4-bit hex nibble of a packed input word. Digits are scanned one at a time at a programmable rate.
- Adds per-digit decimal points, optional leading-zero blanking, tear-free frame latching and a frame-done pulse.
- Sits between datapath/status registers and the board display pins.

---
 rtl/seg7_scan_driver.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit hex 7-segment scan driver
module seg7_scan_driver #(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 1000,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_lz,
    output logic [7:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                  first_q, first_d;
    logic [7:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  fd_q, fd_d;

    logic [4*N_DIGITS-1:0] src_val;
    logic [N_DIGITS-1:0]   src_dp;
    logic [3:0]            digit;
    logic                  dp_bit;
    logic                  upper_nz;
    logic                  blank;
    logic                  tick;
    logic                  wrap;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'b0000001;
            4'h1: decode = 7'b1001111;
            4'h2: decode = 7'b0010010;
            4'h3: decode = 7'b0000110;
            4'h4: decode = 7'b1001100;
            4'h5: decode = 7'b0100100;
            4'h6: decode = 7'b0100000;
            4'h7: decode = 7'b0001111;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0000100;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b1100000;
            4'hC: decode = 7'b0110001;
            4'hD: decode = 7'b1000010;
            4'hE: decode = 7'b0110000;
            default: decode = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        first_d      = first_q;
        seg_d        = 8'hFF;
        an_d         = '1;
        fd_d         = 1'b0;
        // The first enabled cycle after reset decodes straight from the inputs
        // so the very first slot already shows the frame being captured.
        src_val      = first_q ? value : shadow_val_q;
        src_dp       = first_q ? dp_in : shadow_dp_q;
        digit        = 4'h0;
        dp_bit       = 1'b0;
        upper_nz     = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (IDX_W'(i) == idx_q) begin
                digit  = src_val[4*i +: 4];
                dp_bit = src_dp[i];
            end
            if (IDX_W'(i) >= idx_q && src_val[4*i +: 4] != 4'h0) begin
                upper_nz = 1'b1;
            end
        end
        blank = blank_lz && (idx_q != '0) && !upper_nz;
        tick  = (cnt_q == LAST_CNT);
        wrap  = tick && (idx_q == LAST_IDX);

        if (en) begin
            an_d  = ~(N_DIGITS'(1) << idx_q);
            seg_d = {blank ? 7'h7F : decode(digit), ~dp_bit};
            fd_d  = wrap;
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
            if (tick) begin
                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end
            if (first_q || wrap) begin
                shadow_val_d = value;
                shadow_dp_d  = dp_in;
            end
            first_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            first_q      <= 1'b1;
            seg_q        <= 8'hFF;
            an_q         <= '1;
            fd_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            first_q      <= first_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            fd_q         <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule
